// File: rtl/delay_tap_tuner_pkg.sv
// Shared types and constants for the delay-line tap tuner.
package delay_tap_tuner_pkg;

  // Controller states
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSettle = 3'd1,
    StLaunch = 3'd2,
    StWait   = 3'd3,
    StEval   = 3'd4,
    StDone   = 3'd5
  } state_e;

  // Averaging: number of measurements per tap and the matching divide shift
  localparam int unsigned AVG_N     = 4;
  localparam int unsigned AVG_SHIFT = 2;

  // Default widths and timing
  localparam int unsigned TapWDef       = 4;
  localparam int unsigned CntWDef       = 8;
  localparam int unsigned TimeoutDef    = 200;
  localparam int unsigned SettleCycDef  = 4;
  localparam int unsigned SyncStagesDef = 2;

endpackage

// File: rtl/delay_tap_tuner_sync.sv
// Multi-flop synchronizer for the returning probe edge; resets to 0.
module delay_tap_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/delay_tap_tuner.sv
// Delay-line tap calibration controller: launches a probe edge through the
// selected tap, counts cycles until it returns, and steps the tap upward until
// the measured delay meets the target.
// Optional build macro DELAY_TAP_TUNER_AVG_EN: average four measurements per tap.
module delay_tap_tuner
  import delay_tap_tuner_pkg::*;
#(
  parameter int unsigned TAP_W       = TapWDef,
  parameter int unsigned CNT_W       = CntWDef,
  parameter int unsigned TIMEOUT     = TimeoutDef,
  parameter int unsigned SETTLE_CYC  = SettleCycDef,
  parameter int unsigned SYNC_STAGES = SyncStagesDef
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] target_i,
  output logic [TAP_W-1:0] tap_sel_o,
  output logic             probe_out_o,
  input  logic             probe_in_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             lock_ok_o,
  output logic [CNT_W-1:0] measured_o,
  output logic             err_timeout_o
);

  localparam int unsigned SetW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_e           state_q;
  logic [TAP_W-1:0] tap_q;
  logic             probe_q;
  logic [CNT_W-1:0] cnt_q;
  logic [SetW-1:0]  settle_q;
  logic [CNT_W-1:0] target_q;
  logic             busy_q;
  logic             done_q;
  logic             lock_q;
  logic [CNT_W-1:0] meas_q;
  logic             err_q;
  logic             echo;
  logic [CNT_W-1:0] eval_cnt;

`ifdef DELAY_TAP_TUNER_AVG_EN
  localparam int unsigned AccW = CNT_W + AVG_SHIFT;
  logic [AccW-1:0] acc_q;
  logic [1:0]      rep_q;
`endif

  delay_tap_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d_i(probe_in_i),
    .q_o(echo)
  );

  // Value used for the lock decision and reported as measured
  always_comb begin
`ifdef DELAY_TAP_TUNER_AVG_EN
    eval_cnt = acc_q[AccW-1:AVG_SHIFT];
`else
    eval_cnt = cnt_q;
`endif
  end

  // Calibration sequencer with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      tap_q    <= '0;
      probe_q  <= 1'b0;
      cnt_q    <= '0;
      settle_q <= '0;
      target_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      lock_q   <= 1'b0;
      meas_q   <= '0;
      err_q    <= 1'b0;
`ifdef DELAY_TAP_TUNER_AVG_EN
      acc_q    <= '0;
      rep_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            target_q <= target_i;
            tap_q    <= '0;
            lock_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b1;
            settle_q <= '0;
`ifdef DELAY_TAP_TUNER_AVG_EN
            acc_q    <= '0;
            rep_q    <= '0;
`endif
            state_q  <= StSettle;
          end
        end
        StSettle: begin
          if (settle_q == SetW'(SETTLE_CYC - 1)) begin
            settle_q <= '0;
            state_q  <= StLaunch;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        StLaunch: begin
          probe_q <= ~probe_q;
          cnt_q   <= '0;
          state_q <= StWait;
        end
        StWait: begin
          if (echo == probe_q) begin
`ifdef DELAY_TAP_TUNER_AVG_EN
            acc_q <= acc_q + AccW'(cnt_q);
            if (rep_q == 2'(AVG_N - 1)) begin
              state_q <= StEval;
            end else begin
              rep_q   <= rep_q + 1'b1;
              state_q <= StSettle;
            end
`else
            state_q <= StEval;
`endif
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            // Probe never came back; tap is left where it was
            cnt_q   <= cnt_q + 1'b1;
            err_q   <= 1'b1;
            lock_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StEval: begin
          meas_q <= eval_cnt;
          if (eval_cnt >= target_q) begin
            lock_q  <= 1'b1;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else if (&tap_q) begin
            // Longest tap still too short: report failure to lock
            lock_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            tap_q   <= tap_q + 1'b1;
`ifdef DELAY_TAP_TUNER_AVG_EN
            acc_q   <= '0;
            rep_q   <= '0;
`endif
            state_q <= StSettle;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tap_sel_o     = tap_q;
  assign probe_out_o   = probe_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign lock_ok_o     = lock_q;
  assign measured_o    = meas_q;
  assign err_timeout_o = err_q;

endmodule

// File: tb/tb_delay_tap_tuner.sv
// Self-checking bench for delay_tap_tuner with a behavioural delay line and
// a transaction-level model of the calibration outcome and timing.
module tb_delay_tap_tuner;

  localparam int TapW       = 4;
  localparam int CntW       = 8;
  localparam int Timeout    = 200;
  localparam int SettleCyc  = 4;
  localparam int SyncStages = 2;

`ifdef DELAY_TAP_TUNER_AVG_EN
  localparam int NMeas     = 4;
  localparam int LatLoop   = 33;
  localparam int LatT5     = 156;
  localparam int LatT30    = 1008;
`else
  localparam int NMeas     = 1;
  localparam int LatLoop   = 9;
  localparam int LatT5     = 42;
  localparam int LatT30    = 264;
`endif
  localparam int LatTout   = 205;

  localparam int LineDelay = 0;
  localparam int LineLoop  = 1;
  localparam int LineTie0  = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [CntW-1:0] target = '0;
  logic [TapW-1:0] tap_sel;
  logic            probe_out;
  logic            probe_in;
  logic            busy;
  logic            done;
  logic            lock_ok;
  logic [CntW-1:0] measured;
  logic            err_timeout;

  int n_tot = 0;
  int n_bad = 0;
  int n_done = 0;
  int line_mode = LineDelay;
  logic [15:0] sh = '0;

  delay_tap_tuner #(
    .TAP_W(TapW), .CNT_W(CntW), .TIMEOUT(Timeout),
    .SETTLE_CYC(SettleCyc), .SYNC_STAGES(SyncStages)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start), .target_i(target),
    .tap_sel_o(tap_sel), .probe_out_o(probe_out), .probe_in_i(probe_in),
    .busy_o(busy), .done_o(done), .lock_ok_o(lock_ok),
    .measured_o(measured), .err_timeout_o(err_timeout)
  );

  always #5 clk = ~clk;

  // Delay line: tap k returns probe_out delayed by k clock edges
  always @(posedge clk) sh <= {sh[14:0], probe_out};
  assign probe_in = (line_mode == LineTie0) ? 1'b0 :
                    ((line_mode == LineLoop) || (tap_sel == '0)) ? probe_out :
                    sh[tap_sel - 4'd1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Outcome of one calibration run from the rules: per tap, settle + launch +
  // (m+1) wait cycles per measurement, one evaluation cycle; timeout aborts.
  task automatic plan(input int tgt, input int mode, inout bit prb, output int total,
                      output int tap, output bit lock, output bit err,
                      output bit has_meas, output int meas);
    total = 0; tap = 0; lock = 0; err = 0; has_meas = 0; meas = 0;
    for (int t = 0; t < 16; t++) begin
      int acc;
      acc = 0;
      tap = t;
      for (int i = 0; i < NMeas; i++) begin
        int m;
        prb = ~prb;
        if (mode == LineTie0) m = (prb == 1'b0) ? 0 : Timeout;
        else if (mode == LineLoop) m = SyncStages;
        else m = t + SyncStages;
        if (m >= Timeout) begin
          total += SettleCyc + 1 + Timeout;
          err = 1;
          return;
        end
        total += SettleCyc + 1 + m + 1;
        acc += m;
      end
      total += 1;
      meas = acc / NMeas;
      has_meas = 1;
      if (meas >= tgt) begin
        lock = 1;
        return;
      end
      if (t == 15) return;
    end
  endtask

  // Model state
  int cyc, m_fin, m_tap, m_meas;
  bit m_busy, m_done, m_lock, m_err, m_prb;
  int p_total, p_tap, p_meas;
  bit p_lock, p_err, p_has;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc = 0; m_busy = 0; m_done = 0; m_lock = 0; m_err = 0;
      m_tap = 0; m_meas = 0; m_prb = 0; m_fin = 0;
    end else begin
      cyc++;
      if (m_busy) begin
        if (cyc == m_fin) begin
          m_done = 1; m_tap = p_tap; m_lock = p_lock; m_err = p_err;
          if (p_has) m_meas = p_meas;
        end else if (cyc == m_fin + 1) begin
          m_done = 0; m_busy = 0;
        end
      end else if (start) begin
        m_busy = 1; m_lock = 0; m_err = 0; m_tap = 0;
        plan(int'(target), line_mode, m_prb, p_total, p_tap, p_lock, p_err, p_has, p_meas);
        m_fin = cyc + p_total;
      end
    end
  end

  // Cycle compare against the model
  always @(negedge clk) begin
    if (!rst) begin
      check("cyc busy", busy, m_busy);
      check("cyc done", done, m_done);
      check("cyc lock_ok", lock_ok, m_lock);
      check("cyc err_timeout", err_timeout, m_err);
      if (!m_busy || m_done) begin
        check("cyc tap_sel", tap_sel, m_tap);
        check("cyc measured", measured, m_meas);
      end
      if (!m_busy) check("cyc probe_out", probe_out, m_prb);
    end
  end

  always @(negedge clk) if (done) n_done++;

  task automatic run(input int tgt, input int poke_at, input int poke_tgt, output int lat);
    @(negedge clk);
    start = 1'b1;
    target = CntW'(tgt);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 2000) begin
      @(negedge clk);
      lat++;
      start = (lat == poke_at);
      if (lat == poke_at) target = CntW'(poke_tgt);
    end
    start = 1'b0;
    check("run reached done", done, 1'b1);
    @(negedge clk);
    check("busy low after done", busy, 1'b0);
  endtask

  initial begin
    int lat, k;
    #1 rst = 1'b1;
    #1;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst tap_sel", tap_sel, 0);
    check("rst measured", measured, 0);
    check("rst lock_ok", lock_ok, 0);
    check("rst err_timeout", err_timeout, 0);
    check("rst probe_out", probe_out, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Lost probe: line tied low while probe_out rises
    line_mode = LineTie0;
    n_done = 0;
    run(100, -1, 0, lat);
    check("tout latency", lat, LatTout);
    check("tout err_timeout", err_timeout, 1);
    check("tout lock_ok", lock_ok, 0);
    check("tout tap_sel", tap_sel, 0);
    check("tout probe_out", probe_out, 1);
    check("tout done pulses", n_done, 1);

    // Resynchronize the line, then zero-delay loopback
    line_mode = LineLoop;
    repeat (20) @(negedge clk);
    run(2, -1, 0, lat);
    check("loop latency", lat, LatLoop);
    check("loop tap_sel", tap_sel, 0);
    check("loop measured", measured, 2);
    check("loop lock_ok", lock_ok, 1);
    check("loop err cleared", err_timeout, 0);

    // Delay line = tap cycles
    line_mode = LineDelay;
    repeat (20) @(negedge clk);
    n_done = 0;
    run(5, -1, 0, lat);
    check("t5 latency", lat, LatT5);
    check("t5 tap_sel", tap_sel, 3);
    check("t5 measured", measured, 5);
    check("t5 lock_ok", lock_ok, 1);
    repeat (3) @(negedge clk);
    check("t5 done pulses", n_done, 1);

    run(30, -1, 0, lat);
    check("t30 latency", lat, LatT30);
    check("t30 tap_sel", tap_sel, 15);
    check("t30 measured", measured, 17);
    check("t30 lock_ok", lock_ok, 0);
    check("t30 err_timeout", err_timeout, 0);

    run(17, -1, 0, lat);
    check("t17 tap_sel", tap_sel, 15);
    check("t17 measured", measured, 17);
    check("t17 lock_ok", lock_ok, 1);

    run(0, -1, 0, lat);
    check("t0 latency", lat, LatLoop);
    check("t0 tap_sel", tap_sel, 0);
    check("t0 measured", measured, 2);
    check("t0 lock_ok", lock_ok, 1);

    // Start while busy is ignored, new target has no effect
    n_done = 0;
    run(5, 10, 0, lat);
    check("poke latency", lat, LatT5);
    check("poke tap_sel", tap_sel, 3);
    check("poke measured", measured, 5);
    check("poke lock_ok", lock_ok, 1);
    repeat (3) @(negedge clk);
    check("poke done pulses", n_done, 1);

    // Reset in the middle of a WAIT at tap 2
    @(negedge clk);
    start = 1'b1;
    target = 8'd30;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (tap_sel != 4'd2 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("reach tap 2", tap_sel, 2);
    repeat (6) @(negedge clk);
    check("mid-run busy", busy, 1);
    n_done = 0;
    #2 rst = 1'b1;
    #1;
    check("mid rst busy", busy, 0);
    check("mid rst done", done, 0);
    check("mid rst tap_sel", tap_sel, 0);
    check("mid rst measured", measured, 0);
    check("mid rst lock_ok", lock_ok, 0);
    check("mid rst err_timeout", err_timeout, 0);
    check("mid rst probe_out", probe_out, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("no done after rst", n_done, 0);

    // Fresh run after the abort
    run(5, -1, 0, lat);
    check("post rst tap_sel", tap_sel, 3);
    check("post rst measured", measured, 5);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got time %0t want finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
